// File: rtl/grant_rr_arbiter.sv
// rtl/grant_rr_arbiter.sv - round-robin grant arbiter with per-grant hold limit
module grant_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam int ID_W = $clog2(N);
  localparam int HC_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t          state, state_n;
  logic [N-1:0]    gnt_n;
  logic [ID_W-1:0] gnt_id_n;
  logic            busy_n;
  logic            timeout_n;
  logic [ID_W-1:0] last_id, last_id_n;
  logic [HC_W-1:0] hold_cnt, hold_cnt_n;
  logic [N-1:0]    mask, mask_n;
  logic [N-1:0]    eligible;
  logic            pick_found;
  logic [ID_W-1:0] pick_id;

  assign eligible = req & ~mask;

  // Search starts just after the previous owner, wrapping modulo N.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int i = 1; i <= N; i++) begin
      if (!pick_found && eligible[ID_W'((int'(last_id) + i) % N)]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'((int'(last_id) + i) % N);
      end
    end
  end

  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    gnt_id_n   = gnt_id;
    timeout_n  = 1'b0;
    last_id_n  = last_id;
    hold_cnt_n = hold_cnt;
    mask_n     = mask & req;

    case (state)
      IDLE: begin
        gnt_id_n = '0;
        if (pick_found) begin
          state_n    = GRANT;
          gnt_n      = '0;
          gnt_n[pick_id] = 1'b1;
          gnt_id_n   = pick_id;
          last_id_n  = pick_id;
          hold_cnt_n = HC_W'(1);
        end
      end
      GRANT: begin
        if (!req[gnt_id]) begin
          state_n = RELEASE;
          gnt_n   = '0;
        end else if (hold_cnt == HC_W'(MAX_HOLD)) begin
          // Masked owner must drop req once before it can win again.
          state_n          = RELEASE;
          gnt_n            = '0;
          timeout_n        = 1'b1;
          mask_n[gnt_id]   = 1'b1;
        end else begin
          hold_cnt_n = hold_cnt + HC_W'(1);
        end
      end
      RELEASE: begin
        state_n    = IDLE;
        gnt_n      = '0;
        gnt_id_n   = '0;
        hold_cnt_n = '0;
      end
      default: begin
        state_n  = IDLE;
        gnt_n    = '0;
        gnt_id_n = '0;
      end
    endcase

    busy_n = |gnt_n;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      last_id  <= ID_W'(N - 1);
      hold_cnt <= '0;
      mask     <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      gnt_id   <= gnt_id_n;
      busy     <= busy_n;
      timeout  <= timeout_n;
      last_id  <= last_id_n;
      hold_cnt <= hold_cnt_n;
      mask     <= mask_n;
    end
  end

endmodule

// File: tb/tb_grant_rr_arbiter.sv
// tb/tb_grant_rr_arbiter.sv - self-checking bench for grant_rr_arbiter
module tb_grant_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req   = '0;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         timeout;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the resource, how long, and who is blocked.
  int m_owner;
  int m_held;
  bit m_dead;
  int m_last;
  int m_gid;
  bit m_to;
  bit m_blocked [N];

  grant_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_dead  = 0;
    m_last  = N - 1;
    m_gid   = 0;
    m_to    = 0;
    for (int i = 0; i < N; i++) m_blocked[i] = 0;
  endtask

  function automatic logic [N-1:0] m_gnt_vec();
    logic [N-1:0] v;
    v = '0;
    if (m_owner >= 0) v[m_owner] = 1'b1;
    return v;
  endfunction

  task automatic model_step(input logic [N-1:0] r);
    int k;
    int set_idx;
    set_idx = -1;
    m_to = 0;
    if (m_dead) begin
      m_dead = 0;
      m_gid  = 0;
    end else if (m_owner < 0) begin
      m_gid = 0;
      for (int j = 1; j <= N; j++) begin
        k = (m_last + j) % N;
        if (r[k] && !m_blocked[k]) begin
          m_owner = k;
          m_held  = 1;
          m_last  = k;
          m_gid   = k;
          break;
        end
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
      m_dead  = 1;
    end else if (m_held == MAX_HOLD) begin
      set_idx = m_owner;
      m_to    = 1;
      m_owner = -1;
      m_dead  = 1;
    end else begin
      m_held++;
    end
    for (int i = 0; i < N; i++) if (!r[i]) m_blocked[i] = 0;
    if (set_idx >= 0) m_blocked[set_idx] = 1;
  endtask

  task automatic tick();
    logic [N-1:0] r;
    @(posedge clock);
    r = req;
    model_step(r);
    #1;
    check("m_gnt", 32'(gnt), 32'(m_gnt_vec()));
    check("m_gnt_id", 32'(gnt_id), 32'(m_gid));
    check("m_busy", 32'(busy), 32'(m_owner >= 0));
    check("m_timeout", 32'(timeout), 32'(m_to));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    repeat (2) @(posedge clock);
    #2;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_gnt_id", 32'(gnt_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_timeout", 32'(timeout), 0);
    reset = 1'b0;
    model_reset();
  endtask

  logic [N-1:0] seq_gnt [13] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0};
  bit           seq_to  [13] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0};

  initial begin
    int down, ngrants, gap, idx, run, last_run;
    logic [N-1:0] prev_g;

    model_reset();
    do_reset();

    // Single requester: grant latency and release latency.
    repeat (9) tick();
    req = 4'b0001;
    tick();
    check("t1_gnt", 32'(gnt), 1);
    check("t1_gnt_id", 32'(gnt_id), 0);
    check("t1_busy", 32'(busy), 1);
    tick();
    req = 4'b0000;
    tick();
    check("t1_rel_gnt", 32'(gnt), 0);
    check("t1_rel_busy", 32'(busy), 0);
    tick();
    check("t1_idle_busy", 32'(busy), 0);

    // All requesting, each drops after two granted cycles.
    do_reset();
    req = 4'b1111;
    down = -1; ngrants = 0; gap = 0; prev_g = '0;
    for (int c = 0; c < 80 && ngrants < 6; c++) begin
      if (down >= 0) begin
        req[down] = 1'b1;
        down = -1;
      end
      if (m_owner >= 0 && m_held == 2) begin
        req[m_owner] = 1'b0;
        down = m_owner;
      end
      tick();
      check("rr_onehot", 32'($onehot0(gnt)), 1);
      if (gnt != 0 && prev_g == 0) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (gnt[i]) idx = i;
        check("rr_order", idx, ngrants % N);
        if (ngrants > 0) check("rr_gap", gap, 2);
        ngrants++;
        gap = 0;
      end else if (gnt == 0) begin
        gap++;
      end
      prev_g = gnt;
    end
    check("rr_count", ngrants, 6);

    // Constant 0110: hold limit, timeout pulse, masking.
    do_reset();
    req = 4'b0110;
    for (int c = 0; c < 13; c++) begin
      tick();
      check("hold_gnt", 32'(gnt), 32'(seq_gnt[c]));
      check("hold_to", 32'(timeout), 32'(seq_to[c]));
    end
    req = 4'b0100;
    tick();
    check("mask_gnt_a", 32'(gnt), 0);
    req = 4'b0110;
    tick();
    check("mask_gnt_b", 32'(gnt), 32'h2);

    // Asynchronous reset while requester 2 owns the grant.
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    check("ar_pre_gnt", 32'(gnt), 32'h4);
    #2;
    reset = 1'b1;
    #1;
    check("ar_gnt", 32'(gnt), 0);
    check("ar_busy", 32'(busy), 0);
    model_reset();
    req = 4'b1001;
    @(posedge clock);
    #2;
    reset = 1'b0;
    tick();
    check("ar_first", 32'(gnt), 32'h1);

    // req[3] seen only during RELEASE after a requester-1 grant.
    do_reset();
    req = 4'b0010;
    tick();
    check("rel_pre", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick();
    req = 4'b1000;
    tick();
    check("rel_busy_a", 32'(busy), 0);
    req = 4'b0000;
    tick();
    check("rel_busy_b", 32'(busy), 0);

    // Random traffic against the model plus structural invariants.
    do_reset();
    run = 0; last_run = 0; prev_g = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) req[i] = ~req[i];
      tick();
      check("rnd_onehot", 32'($onehot0(gnt)), 1);
      check("rnd_busy", 32'(busy), 32'(|gnt));
      if (gnt != 0) begin
        run = (gnt == prev_g) ? run + 1 : 1;
        check("rnd_hold", 32'(run <= MAX_HOLD), 1);
      end else begin
        if (prev_g != 0) last_run = run;
        if (timeout) check("rnd_to_limit", last_run, MAX_HOLD);
        run = 0;
      end
      prev_g = gnt;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
